// File: rtl/cache_test_sequencer.sv
// Walks the cache-test instruction ROM from index 0 and issues each valid entry
// to the cache under a req/ack handshake, collecting latency and hit/miss counts.
module cache_test_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       rom_index,
    input  logic             rom_valid,
    input  logic             rom_write,
    input  logic [31:0]      rom_addr,
    input  logic [2:0]       rom_u_b_h_w,
    output logic             cache_req,
    output logic             cache_write,
    output logic [31:0]      cache_addr,
    output logic [2:0]       cache_u_b_h_w,
    output logic [31:0]      cache_din,
    input  logic             cache_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] total_cycles,
    output logic [7:0]       hit_cnt,
    output logic [7:0]       miss_cnt,
    output logic [7:0]       last_lat
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [15:0]      TIMEOUT_L = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TOT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TOT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       rom_index_q, rom_index_d;
    logic             req_q, req_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [2:0]       ubhw_q, ubhw_d;
    logic [31:0]      din_q, din_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [7:0]       hit_q, hit_d;
    logic [7:0]       miss_q, miss_d;
    logic [7:0]       last_q, last_d;
    logic [15:0]      lat_q, lat_d;
    logic [15:0]      latency_s;

    // Latency of the current request if it completes in this cycle.
    assign latency_s = lat_q + 16'd1;

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d     = state_q;
        rom_index_d = rom_index_q;
        req_d       = req_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        ubhw_d      = ubhw_q;
        din_d       = din_q;
        tot_d       = tot_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        last_d      = last_q;
        lat_d       = lat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_CHECK;
                    rom_index_d = 4'h0;
                    tot_d       = TOT_ZERO;
                    hit_d       = 8'h00;
                    miss_d      = 8'h00;
                    last_d      = 8'h00;
                end else begin
                    state_d = state_q;
                end
            end
            S_CHECK: begin
                if (!rom_valid) begin
                    state_d = S_DONE;
                end else begin
                    wr_d    = rom_write;
                    addr_d  = rom_addr;
                    ubhw_d  = rom_u_b_h_w;
                    din_d   = {24'hA5A5A5, 4'h0, rom_index_q};
                    lat_d   = 16'd0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                tot_d = (tot_q == TOT_MAX) ? tot_q : tot_q + TOT_ONE;
                if (cache_ack) begin
                    last_d = (latency_s > 16'd255) ? 8'hFF : latency_s[7:0];
                    if (latency_s == 16'd1) begin
                        hit_d = sat_inc8(hit_q);
                    end else begin
                        miss_d = sat_inc8(miss_q);
                    end
                    req_d = 1'b0;
                    // Index 15 is the last ROM slot; finish there rather than wrap.
                    if (rom_index_q == 4'hF) begin
                        state_d = S_DONE;
                    end else begin
                        rom_index_d = rom_index_q + 4'h1;
                        state_d     = S_CHECK;
                    end
                end else if (latency_s == TIMEOUT_L) begin
                    req_d   = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    lat_d = latency_s;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rom_index_q <= 4'h0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            ubhw_q      <= 3'b000;
            din_q       <= 32'h0000_0000;
            tot_q       <= TOT_ZERO;
            hit_q       <= 8'h00;
            miss_q      <= 8'h00;
            last_q      <= 8'h00;
            lat_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            rom_index_q <= rom_index_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            ubhw_q      <= ubhw_d;
            din_q       <= din_d;
            tot_q       <= tot_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            last_q      <= last_d;
            lat_q       <= lat_d;
        end
    end

    assign rom_index     = rom_index_q;
    assign cache_req     = req_q;
    assign cache_write   = wr_q;
    assign cache_addr    = addr_q;
    assign cache_u_b_h_w = ubhw_q;
    assign cache_din     = din_q;
    assign total_cycles  = tot_q;
    assign hit_cnt       = hit_q;
    assign miss_cnt      = miss_q;
    assign last_lat      = last_q;
    assign busy          = (state_q == S_CHECK) || (state_q == S_REQ);
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);

endmodule

// File: tb/tb_cache_test_sequencer.sv
// Directed bench for cache_test_sequencer: a table-driven ROM and cache latency
// model, a per-cycle output check, and per-run result checks.
module tb_cache_test_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rom_index;
    logic        rom_valid, rom_write;
    logic [31:0] rom_addr;
    logic [2:0]  rom_u_b_h_w;
    logic        cache_req, cache_write;
    logic [31:0] cache_addr, cache_din;
    logic [2:0]  cache_u_b_h_w;
    logic        cache_ack = 1'b0;
    logic        busy, done, error;
    logic [15:0] total_cycles;
    logic [7:0]  hit_cnt, miss_cnt, last_lat;

    cache_test_sequencer #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_index(rom_index), .rom_valid(rom_valid), .rom_write(rom_write),
        .rom_addr(rom_addr), .rom_u_b_h_w(rom_u_b_h_w),
        .cache_req(cache_req), .cache_write(cache_write), .cache_addr(cache_addr),
        .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din), .cache_ack(cache_ack),
        .busy(busy), .done(done), .error(error), .total_cycles(total_cycles),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .last_lat(last_lat)
    );

    always #5 clk = ~clk;

    // ROM contents and per-entry cache latency (0 = cache never acks).
    logic        rv[16];
    logic        rw[16];
    logic [31:0] ra[16];
    logic [2:0]  rs[16];
    int          lat_t[16];

    assign rom_valid   = rv[rom_index];
    assign rom_write   = rw[rom_index];
    assign rom_addr    = ra[rom_index];
    assign rom_u_b_h_w = rs[rom_index];

    int tests = 0;
    int fails = 0;
    int req_cyc = 0;
    int exp_tot = 0;
    bit chk_en = 1'b0;
    int last_edges;

    // Expected run results derived from the tables.
    int m_tot, m_hit, m_miss, m_last, m_edges, m_idx, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Cache model and per-cycle compare, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (cache_req) begin
            req_cyc++;
            cache_ack = (lat_t[rom_index] != 0) && (req_cyc == lat_t[rom_index]);
        end else begin
            req_cyc   = 0;
            cache_ack = 1'b0;
        end
        if (!chk_en) begin
            exp_tot = 0;
        end else begin
            chk("cyc_total", 32'(total_cycles), exp_tot);
            chk("cyc_busy", 32'(busy), 32'(!(done || error)));
            if (cache_req) begin
                exp_tot++;
                chk("cyc_addr", cache_addr, ra[rom_index]);
                chk("cyc_write", 32'(cache_write), 32'(rw[rom_index]));
                chk("cyc_size", 32'(cache_u_b_h_w), 32'(rs[rom_index]));
                chk("cyc_din", cache_din, {24'hA5A5A5, 4'h0, rom_index});
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 32'h0; rs[i] = 3'd0; lat_t[i] = 1;
        end
    endtask

    task automatic load_prog(input int n, input int lats[16]);
        clear_prog();
        for (int i = 0; i < n; i++) begin
            rv[i]    = 1'b1;
            rw[i]    = i[0];
            ra[i]    = 32'h8000_0000 + 32'(i * 68);
            rs[i]    = 3'(i % 5);
            lat_t[i] = lats[i];
        end
    endtask

    task automatic compute_model();
        m_tot = 0; m_hit = 0; m_miss = 0; m_last = 0; m_edges = 0; m_idx = 0; m_err = 0;
        for (int i = 0; i < 16; i++) begin
            m_idx = i;
            if (!rv[i]) begin
                m_edges += 1;
                break;
            end
            if (lat_t[i] == 0) begin
                m_tot += 64; m_edges += 65; m_err = 1;
                break;
            end
            m_tot   += lat_t[i];
            m_edges += 1 + lat_t[i];
            m_last   = lat_t[i];
            if (lat_t[i] == 1) m_hit++; else m_miss++;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #2; start = 1'b1; chk_en = 1'b0;
        @(posedge clk); #2; start = 1'b0; chk_en = 1'b1;
    endtask

    task automatic run_prog(input int budget, input bit poke);
        int edges;
        pulse_start();
        edges = 0;
        while (!(done || error) && edges < budget) begin
            @(posedge clk); edges++; #2;
            start = (poke && edges == 5);
        end
        start = 1'b0;
        last_edges = edges;
        if (!(done || error)) chk("run_bound", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag);
        compute_model();
        chk({tag, "_total"}, 32'(total_cycles), m_tot);
        chk({tag, "_hit"}, 32'(hit_cnt), m_hit);
        chk({tag, "_miss"}, 32'(miss_cnt), m_miss);
        chk({tag, "_last"}, 32'(last_lat), m_last);
        chk({tag, "_index"}, 32'(rom_index), m_idx);
        chk({tag, "_edges"}, last_edges, m_edges);
        chk({tag, "_error"}, 32'(error), m_err);
        chk({tag, "_done"}, 32'(done), 32'(m_err == 0));
        chk({tag, "_req_low"}, 32'(cache_req), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_index"}, 32'(rom_index), 32'd0);
        chk({tag, "_req"}, 32'(cache_req), 32'd0);
        chk({tag, "_write"}, 32'(cache_write), 32'd0);
        chk({tag, "_addr"}, cache_addr, 32'd0);
        chk({tag, "_size"}, 32'(cache_u_b_h_w), 32'd0);
        chk({tag, "_din"}, cache_din, 32'd0);
        chk({tag, "_flags"}, 32'({busy, done, error}), 32'd0);
        chk({tag, "_total"}, 32'(total_cycles), 32'd0);
        chk({tag, "_counts"}, {8'd0, hit_cnt, miss_cnt, last_lat}, 32'd0);
    endtask

    int std_lat[16]  = '{18, 1, 18, 35, 1, 18, 1, 18, 18, 0, 0, 0, 0, 0, 0, 0};
    int stl_lat[16]  = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int hit_lat[16]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        rst = 1'b0; start = 1'b0;
        clear_prog();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        rst = 1'b1;

        // Standard 9-entry program.
        load_prog(9, std_lat);
        run_prog(1000, 1'b0);
        check_results("std");
        chk("std_lit_total", 32'(total_cycles), 32'd128);
        chk("std_lit_hit", 32'(hit_cnt), 32'd3);
        chk("std_lit_miss", 32'(miss_cnt), 32'd6);
        chk("std_lit_last", 32'(last_lat), 32'd18);
        chk("std_lit_edges", last_edges, 32'd138);
        chk("std_lit_index", 32'(rom_index), 32'd9);

        // Restart from DONE with a start pulse during REQ; results must repeat.
        run_prog(1000, 1'b1);
        check_results("rerun");
        chk("rerun_lit_total", 32'(total_cycles), 32'd128);
        chk("rerun_lit_edges", last_edges, 32'd138);

        // Empty program.
        clear_prog();
        run_prog(100, 1'b0);
        check_results("empty");
        chk("empty_lit_edges", last_edges, 32'd1);
        chk("empty_no_req", exp_tot, 32'd0);

        // Entry 2 never acknowledged.
        load_prog(6, stl_lat);
        run_prog(1000, 1'b0);
        check_results("stall");
        chk("stall_lit_index", 32'(rom_index), 32'd2);
        chk("stall_lit_err", 32'(error), 32'd1);
        chk("stall_lit_hm", 32'(hit_cnt) + 32'(miss_cnt), 32'd2);
        chk("stall_lit_total", 32'(total_cycles), 32'd66);

        // All 16 entries hit; must stop at index 15.
        load_prog(16, hit_lat);
        run_prog(1000, 1'b0);
        check_results("full");
        chk("full_lit_index", 32'(rom_index), 32'd15);
        chk("full_lit_hit", 32'(hit_cnt), 32'd16);
        chk("full_lit_total", 32'(total_cycles), 32'd16);
        chk("full_lit_done", 32'(done), 32'd1);

        // Asynchronous reset in the 5th cycle of a miss, then a clean rerun.
        load_prog(9, std_lat);
        pulse_start();
        begin
            int guard = 0;
            while (req_cyc != 5 && guard < 200) begin
                @(negedge clk); #1; guard++;
            end
            if (req_cyc != 5) chk("midrst_bound", 32'd0, 32'd1);
        end
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk); #2; rst = 1'b1;
        run_prog(1000, 1'b0);
        check_results("after_rst");
        chk("after_rst_lit_total", 32'(total_cycles), 32'd128);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
